frame_checker: RTL and testbench

FRAME_CHECKER -- requirements
Module: frame_checker

---
 rtl/frame_checker.sv | 169 ++++++++++++++++
 tb/tb_frame_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_checker.sv
// Frame alignment checker: hunts for a K28.5 comma at either byte alignment, then
// verifies the fixed 4-word frame, declares lock and counts good and bad frames while locked.
`timescale 1ns/1ps
module frame_checker #(
    parameter int LOCK_FRAMES = 4,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_ready,
    input  logic [15:0]      rx_data,
    input  logic [1:0]       rx_is_k,
    input  logic             cnt_clear,
    output logic             locked,
    output logic             byte_offset,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

    localparam int GR_W = $clog2(LOCK_FRAMES + 1);
    localparam int BR_W = $clog2(UNLOCK_ERRS + 1);

    state_t           r_state, w_state_next;
    logic [1:0]       r_index, w_index_next;
    logic [GR_W-1:0]  r_good_run, w_good_next, w_good_inc;
    logic [BR_W-1:0]  r_bad_run, w_bad_next, w_bad_inc;
    logic             r_byte_offset, w_offset_next;
    logic             r_frame_bad, w_frame_bad_next;
    logic             r_frame_err, w_frame_err_next;
    logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt_next;
    // Only the high byte of the previous word is ever needed for the shifted alignment.
    logic [15:8]      r_prev_data;
    logic             r_prev_k1;

    logic [15:0] w_sh_data, w_al_data, w_exp_data;
    logic [1:0]  w_sh_k, w_al_k, w_exp_k;
    logic        w_comma0, w_comma1, w_word_bad, w_frame_bad, w_frame_end;

    assign w_sh_data   = {rx_data[7:0], r_prev_data[15:8]};
    assign w_sh_k      = {rx_is_k[0], r_prev_k1};
    assign w_al_data   = r_byte_offset ? w_sh_data : rx_data;
    assign w_al_k      = r_byte_offset ? w_sh_k : rx_is_k;
    assign w_comma0    = (rx_data == 16'hBCBC) && (rx_is_k == 2'b11);
    assign w_comma1    = (w_sh_data == 16'hBCBC) && (w_sh_k == 2'b11);
    assign w_good_inc  = r_good_run + 1'b1;
    assign w_bad_inc   = r_bad_run + 1'b1;
    assign w_frame_end = (r_index == 2'd3);

    always_comb begin
        w_exp_data = 16'hBCBC;
        w_exp_k    = 2'b11;
        case (r_index)
            2'd0:    begin w_exp_data = 16'h5854; w_exp_k = 2'b00; end
            2'd1:    begin w_exp_data = 16'h4034; w_exp_k = 2'b00; end
            2'd2:    begin w_exp_data = 16'h23A7; w_exp_k = 2'b00; end
            default: begin w_exp_data = 16'hBCBC; w_exp_k = 2'b11; end
        endcase
    end

    assign w_word_bad  = (w_al_data != w_exp_data) || (w_al_k != w_exp_k);
    assign w_frame_bad = r_frame_bad | w_word_bad;

    always_comb begin
        w_state_next     = r_state;
        w_index_next     = r_index;
        w_good_next      = r_good_run;
        w_bad_next       = r_bad_run;
        w_offset_next    = r_byte_offset;
        w_frame_bad_next = r_frame_bad;
        w_frame_err_next = 1'b0;
        w_frame_cnt_next = r_frame_cnt;
        w_err_cnt_next   = r_err_cnt;
        if (!rx_ready) begin
            w_state_next     = HUNT;
            w_index_next     = 2'd0;
            w_good_next      = '0;
            w_bad_next       = '0;
            w_frame_bad_next = 1'b0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_comma0 || w_comma1) begin
                        w_offset_next    = !w_comma0;
                        w_index_next     = 2'd0;
                        w_good_next      = '0;
                        w_frame_bad_next = 1'b0;
                        w_state_next     = CHECK;
                    end
                end
                CHECK, LOCKED: begin
                    w_index_next     = r_index + 2'd1;
                    w_frame_bad_next = w_frame_end ? 1'b0 : w_frame_bad;
                    if (w_frame_end) begin
                        w_frame_err_next = w_frame_bad;
                        if (r_state == CHECK) begin
                            if (w_frame_bad) begin
                                w_state_next = HUNT;
                                w_good_next  = '0;
                            end else if (w_good_inc == GR_W'(LOCK_FRAMES)) begin
                                w_state_next = LOCKED;
                                w_bad_next   = '0;
                            end else begin
                                w_good_next  = w_good_inc;
                            end
                        end else if (w_frame_bad) begin
                            if (r_err_cnt != {CNT_W{1'b1}})
                                w_err_cnt_next = r_err_cnt + 1'b1;
                            if (w_bad_inc == BR_W'(UNLOCK_ERRS)) begin
                                w_state_next = HUNT;
                                w_bad_next   = '0;
                            end else begin
                                w_bad_next   = w_bad_inc;
                            end
                        end else begin
                            if (r_frame_cnt != {CNT_W{1'b1}})
                                w_frame_cnt_next = r_frame_cnt + 1'b1;
                            w_bad_next = '0;
                        end
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
        if (cnt_clear) begin
            w_frame_cnt_next = '0;
            w_err_cnt_next   = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= HUNT;
            r_index       <= 2'd0;
            r_good_run    <= '0;
            r_bad_run     <= '0;
            r_byte_offset <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_cnt     <= '0;
            r_prev_data   <= 8'h00;
            r_prev_k1     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_index       <= w_index_next;
            r_good_run    <= w_good_next;
            r_bad_run     <= w_bad_next;
            r_byte_offset <= w_offset_next;
            r_frame_bad   <= w_frame_bad_next;
            r_frame_err   <= w_frame_err_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_err_cnt     <= w_err_cnt_next;
            r_prev_data   <= rx_data[15:8];
            r_prev_k1     <= rx_is_k[1];
        end
    end

    assign locked      = (r_state == LOCKED);
    assign byte_offset = r_byte_offset;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;
    assign state       = r_state;
endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: aligned and byte-shifted lock, loss of lock,
// counter clear/saturation, rx_ready drop and asynchronous reset.
`timescale 1ns/1ps
module tb_frame_checker;
    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          aresetn, rx_ready, cnt_clear;
    logic [15:0]   rx_data;
    logic [1:0]    rx_is_k;
    logic          locked, byte_offset, frame_err;
    logic [CW-1:0] frame_cnt, err_cnt;
    logic [1:0]    state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] w_tab [4];
    logic [1:0]  k_tab [4];
    logic [7:0]  hold_hi;
    logic        hold_hk;

    frame_checker #(.LOCK_FRAMES(4), .UNLOCK_ERRS(4), .CNT_W(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_is_k(rx_is_k), .cnt_clear(cnt_clear), .locked(locked),
        .byte_offset(byte_offset), .frame_err(frame_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .state(state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic [1:0] k);
        rx_data = d;
        rx_is_k = k;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_frame(input bit bad_w1);
        for (int i = 0; i < 4; i++)
            send_word((bad_w1 && i == 1) ? 16'h4035 : w_tab[i], k_tab[i]);
    endtask

    // Same byte stream delayed by one byte: each word carries the previous word's high byte low.
    task automatic send_frame_sh();
        for (int i = 0; i < 4; i++) begin
            send_word({w_tab[i][7:0], hold_hi}, {k_tab[i][0], hold_hk});
            hold_hi = w_tab[i][15:8];
            hold_hk = k_tab[i][1];
        end
    endtask

    initial begin
        w_tab[0] = 16'h5854; w_tab[1] = 16'h4034; w_tab[2] = 16'h23A7; w_tab[3] = 16'hBCBC;
        k_tab[0] = 2'b00;    k_tab[1] = 2'b00;    k_tab[2] = 2'b00;    k_tab[3] = 2'b11;
        hold_hi = 8'h00; hold_hk = 1'b0;
        aresetn = 1'b0; rx_ready = 1'b0; cnt_clear = 1'b0; rx_data = '0; rx_is_k = '0;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_state", state, 0);
        check("rst_locked", locked, 0);
        check("rst_offset", byte_offset, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_fcnt", frame_cnt, 0);
        check("rst_ecnt", err_cnt, 0);

        @(negedge aclk);
        aresetn = 1'b1; rx_ready = 1'b1;
        send_word(16'h0000, 2'b00);
        check("idle_hunt", state, 0);

        // Aligned stream: comma syncs, four good frames lock
        send_frame(0);
        check("a_sync", state, 1);
        repeat (3) send_frame(0);
        check("a_run3", state, 1);
        send_frame(0);
        check("a_state", state, 2);
        check("a_locked", locked, 1);
        check("a_offset", byte_offset, 0);
        check("a_fcnt0", frame_cnt, 0);
        check("a_ferr", frame_err, 0);
        send_frame(0);
        check("a_fcnt1", frame_cnt, 1);
        send_frame(0);
        check("a_fcnt2", frame_cnt, 2);

        // Corrupt w1 while locked
        for (int e = 1; e <= 3; e++) begin
            send_frame(1);
            check("b_ferr", frame_err, 1);
            check("b_ecnt", err_cnt, e);
            check("b_locked", locked, 1);
        end
        send_word(w_tab[0], k_tab[0]);
        check("b_ferr_low", frame_err, 0);
        send_word(16'h4035, 2'b00);
        send_word(w_tab[2], k_tab[2]);
        send_word(w_tab[3], k_tab[3]);
        check("b_unlock_state", state, 0);
        check("b_unlock_locked", locked, 0);
        check("b_ecnt4", err_cnt, 4);
        check("b_ferr4", frame_err, 1);
        check("b_fcnt", frame_cnt, 2);

        // Bad frame during CHECK returns to HUNT without counting
        send_frame(0);
        check("c_sync", state, 1);
        repeat (2) send_frame(0);
        send_frame(1);
        check("c_hunt", state, 0);
        check("c_ferr", frame_err, 1);
        check("c_fcnt", frame_cnt, 2);
        check("c_ecnt", err_cnt, 4);
        send_frame(0);
        check("c_resync", state, 1);
        repeat (3) send_frame(0);
        check("c_run3", state, 1);
        send_frame(0);
        check("c_relock", state, 2);

        // cnt_clear beats a simultaneous increment, then saturation
        for (int i = 0; i < 3; i++) send_word(w_tab[i], k_tab[i]);
        cnt_clear = 1'b1;
        send_word(w_tab[3], k_tab[3]);
        cnt_clear = 1'b0;
        check("d_clr_fcnt", frame_cnt, 0);
        check("d_clr_ecnt", err_cnt, 0);
        check("d_clr_state", state, 2);
        repeat (15) send_frame(0);
        check("d_fcnt15", frame_cnt, 15);
        send_frame(0);
        check("d_fcnt_sat", frame_cnt, 15);
        repeat (4) begin
            repeat (3) send_frame(1);
            send_frame(0);
        end
        check("d_ecnt12", err_cnt, 12);
        repeat (3) send_frame(1);
        send_frame(0);
        check("d_ecnt15", err_cnt, 15);
        check("d_locked", locked, 1);
        send_frame(1);
        check("d_ecnt_sat", err_cnt, 15);
        check("d_ferr_sat", frame_err, 1);
        send_frame(0);

        // rx_ready drop while locked
        cnt_clear = 1'b1;
        send_word(w_tab[0], k_tab[0]);
        cnt_clear = 1'b0;
        for (int i = 1; i < 4; i++) send_word(w_tab[i], k_tab[i]);
        check("f_fcnt1", frame_cnt, 1);
        check("f_ecnt0", err_cnt, 0);
        send_frame(1);
        check("f_ecnt1", err_cnt, 1);
        send_frame(0);
        check("f_fcnt2", frame_cnt, 2);
        send_word(w_tab[0], k_tab[0]);
        send_word(16'h4035, 2'b00);
        send_word(w_tab[2], k_tab[2]);
        rx_ready = 1'b0;
        send_word(w_tab[3], k_tab[3]);
        check("f_state", state, 0);
        check("f_locked", locked, 0);
        check("f_ferr", frame_err, 0);
        check("f_ecnt_hold", err_cnt, 1);
        check("f_fcnt_hold", frame_cnt, 2);
        send_word(w_tab[3], k_tab[3]);
        check("f_comma_ignored", state, 0);

        // Byte-shifted stream
        rx_ready = 1'b1;
        cnt_clear = 1'b1;
        send_word(16'h0000, 2'b00);
        cnt_clear = 1'b0;
        check("g_clr_fcnt", frame_cnt, 0);
        repeat (5) send_frame_sh();
        check("g_run3", state, 1);
        check("g_offset_chk", byte_offset, 1);
        send_frame_sh();
        check("g_state", state, 2);
        check("g_locked", locked, 1);
        check("g_offset", byte_offset, 1);
        check("g_fcnt0", frame_cnt, 0);
        send_frame_sh();
        check("g_fcnt1", frame_cnt, 1);
        check("g_ecnt", err_cnt, 0);

        // Asynchronous reset between clock edges
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("h_state", state, 0);
        check("h_locked", locked, 0);
        check("h_offset", byte_offset, 0);
        check("h_ferr", frame_err, 0);
        check("h_fcnt", frame_cnt, 0);
        check("h_ecnt", err_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        send_word(16'h0000, 2'b00);
        check("h_after", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
